// File: rtl/ysyx_25060170_lsu_pkg.sv
// Shared types and constants for the LSU: FSM states, funct3 access encodings, regS selects.
package ysyx_25060170_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] REGS_ALU = 2'd0;
   localparam logic [1:0] REGS_PC4 = 2'd2;

endpackage

// File: rtl/ysyx_25060170_lsu_if.sv
// Data-memory req/gnt/rvalid bus; the LSU is master, the memory is slave.
interface ysyx_25060170_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// Combinational byte-lane logic: store data replication + write mask, load extract + sign/zero extend.
// Zero latency, no handshake; undefined funct3 behaves as a word access.
module ysyx_25060170_lsu_align
   import ysyx_25060170_lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wmask_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      wdata_o = sdata_i;
      wmask_o = 4'hF;
      case (funct3_i)
         F3_B, F3_BU: begin
            wdata_o = {4{sdata_i[7:0]}};
            wmask_o = 4'b0001 << off_i;
         end
         F3_H, F3_HU: begin
            wdata_o = {2{sdata_i[15:0]}};
            wmask_o = 4'b0011 << {off_i[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_v  = 8'(rdata_i >> {off_i, 3'b000});
      half_v  = 16'(rdata_i >> {off_i[1], 4'b0000});
      ldata_o = rdata_i;
      case (funct3_i)
         F3_B:    ldata_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   ldata_o = {24'd0, byte_v};
         F3_H:    ldata_o = {{16{half_v[15]}}, half_v};
         F3_HU:   ldata_o = {16'd0, half_v};
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: one record per handshake, ALU ops 1 cycle, memory ops wait on gnt/rvalid.
// in_ready only in IDLE; DONE holds until out_ready; optional LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses.
module ysyx_25060170_lsu
   import ysyx_25060170_lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] exu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [2:0]  funct3_i,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [4:0]  rd_i,
   input  logic [1:0]  regS_i,
   input  logic        RegW_i,
   input  logic [31:0] pc_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result_o,
   output logic [4:0]  rd_o,
   output logic [1:0]  regS_o,
   output logic        RegW_o,
   output logic [31:0] pc_o,
   ysyx_25060170_lsu_if.master mem,
   output logic        lsu_err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [2:0]  f3_q, f3_d;
   logic        load_q, load_d;
   logic        store_q, store_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_q, rd_d;
   logic [1:0]  regs_q, regs_d;
   logic        regw_q, regw_d;
   logic [31:0] pc_q, pc_d;
   logic        err_q, err_d;

   logic [31:0] wdata_w;
   logic [3:0]  wmask_w;
   logic [31:0] ldata_w;

   ysyx_25060170_lsu_align u_align (
      .funct3_i (f3_q),
      .off_i    (addr_q[1:0]),
      .sdata_i  (sdata_q),
      .rdata_i  (mem.mem_rdata),
      .wdata_o  (wdata_w),
      .wmask_o  (wmask_w),
      .ldata_o  (ldata_w)
   );

`ifdef LSU_MISALIGN_CHECK_EN
   logic misalign;
   always_comb begin
      misalign = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: misalign = 1'b0;
         F3_H, F3_HU: misalign = exu_result_i[0];
         default:     misalign = (exu_result_i[1:0] != 2'b00);
      endcase
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      f3_d     = f3_q;
      load_d   = load_q;
      store_d  = store_q;
      result_d = result_q;
      rd_d     = rd_q;
      regs_d   = regs_q;
      regw_d   = regw_q;
      pc_d     = pc_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               addr_d   = exu_result_i;
               sdata_d  = store_data_i;
               f3_d     = funct3_i;
               load_d   = MemRd;
               store_d  = MemWr & ~MemRd;
               result_d = exu_result_i;
               rd_d     = rd_i;
               pc_d     = pc_i;
               regs_d   = MemRd ? REGS_ALU : regS_i;
               regw_d   = (MemWr & ~MemRd) ? 1'b0 : RegW_i;
               cnt_d    = 8'd0;
               if (MemRd | MemWr) begin
`ifdef LSU_MISALIGN_CHECK_EN
                  if (misalign) begin
                     state_d = DONE;
                     regw_d  = 1'b0;
                     err_d   = 1'b1;
                  end else begin
                     state_d = REQ;
                  end
`else
                  state_d = REQ;
`endif
               end else begin
                  state_d = DONE;
               end
            end
         end
         REQ, WAIT: begin
            // A response completes the access even in REQ when gnt and rvalid coincide.
            if ((state_q == REQ && mem.mem_gnt && mem.mem_rvalid) ||
                (state_q == WAIT && mem.mem_rvalid)) begin
               state_d = DONE;
               if (load_q) result_d = ldata_w;
            end else if (state_q == REQ && mem.mem_gnt) begin
               state_d = WAIT;
               cnt_d   = 8'd0;
            end else if (cnt_q == TO_LAST) begin
               state_d  = DONE;
               err_d    = 1'b1;
               result_d = 32'd0;
               regw_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         addr_q   <= 32'd0;
         sdata_q  <= 32'd0;
         f3_q     <= 3'd0;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         result_q <= 32'd0;
         rd_q     <= 5'd0;
         regs_q   <= 2'd0;
         regw_q   <= 1'b0;
         pc_q     <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         sdata_q  <= sdata_d;
         f3_q     <= f3_d;
         load_q   <= load_d;
         store_q  <= store_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         regs_q   <= regs_d;
         regw_q   <= regw_d;
         pc_q     <= pc_d;
         err_q    <= err_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign result_o      = result_q;
   assign rd_o          = rd_q;
   assign regS_o        = regs_q;
   assign RegW_o        = regw_q;
   assign pc_o          = pc_q;
   assign lsu_err       = err_q;
   assign mem.mem_req   = (state_q == REQ);
   assign mem.mem_we    = (state_q == REQ) & store_q;
   assign mem.mem_addr  = ADDR_W'({addr_q[31:2], 2'b00});
   assign mem.mem_wdata = wdata_w;
   assign mem.mem_wmask = ((state_q == REQ) & store_q) ? wmask_w : 4'h0;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Randomized bench for ysyx_25060170_lsu with a byte-array memory and an arithmetic reference model.
module tb_ysyx_25060170_lsu;
   import ysyx_25060170_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] exu_result_i, store_data_i, pc_i;
   logic [2:0]  funct3_i;
   logic        MemRd, MemWr, RegW_i;
   logic [4:0]  rd_i;
   logic [1:0]  regS_i;
   logic        out_valid, out_ready;
   logic [31:0] result_o, pc_o;
   logic [4:0]  rd_o;
   logic [1:0]  regS_o;
   logic        RegW_o, lsu_err;

   ysyx_25060170_lsu_if #(.ADDR_W(32)) mem_if ();

   ysyx_25060170_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .exu_result_i(exu_result_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
      .MemRd(MemRd), .MemWr(MemWr), .rd_i(rd_i), .regS_i(regS_i), .RegW_i(RegW_i), .pc_i(pc_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .result_o(result_o), .rd_o(rd_o), .regS_o(regS_o), .RegW_o(RegW_o), .pc_o(pc_o),
      .mem(mem_if), .lsu_err(lsu_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] bmem [0:63];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic int lane_base(input logic [31:0] a, input int sz);
      int off;
      off = int'(a[1:0]);
      return (off / sz) * sz;
   endfunction

   function automatic logic [3:0] exp_mask(input logic [31:0] a, input logic [2:0] f3);
      logic [3:0] m;
      int sz, b;
      sz = acc_size(f3);
      b  = lane_base(a, sz);
      for (int i = 0; i < 4; i++) m[i] = (i >= b) && (i < b + sz);
      return m;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f3);
      logic [31:0] w;
      int sz;
      sz = acc_size(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
      longint v;
      int sz, b, wb;
      sz = acc_size(f3);
      b  = lane_base(a, sz);
      wb = int'(a[5:2]) * 4;
      v  = 0;
      for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(bmem[wb + b + i]);
      if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8*sz - 1)))
         v = v - (longint'(1) << (8*sz));
      return 32'(v);
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      int wb;
      wb = int'(a[5:2]) * 4;
      return {bmem[wb+3], bmem[wb+2], bmem[wb+1], bmem[wb]};
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic do_op(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdn,
                        input logic [1:0] rs, input logic rw, input int gd, input int rdd,
                        input int hold);
      logic is_mem, is_ld, is_st, mis, exp_rw;
      logic [31:0] pcv, exp_res;
      logic [1:0] exp_rs;
      logic [3:0] m;
      logic [31:0] wd;
      int wb;
      is_mem = rd_ | wr_;
      is_ld  = rd_;
      is_st  = wr_ & ~rd_;
      mis    = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis = is_mem && ((acc_size(f3) == 2 && a[0]) || (acc_size(f3) == 4 && a[1:0] != 2'b00));
`endif
      pcv = $urandom;
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      exu_result_i = a; store_data_i = sd; funct3_i = f3; MemRd = rd_; MemWr = wr_;
      rd_i = rdn; regS_i = rs; RegW_i = rw; pc_i = pcv; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exu_result_i = $urandom; store_data_i = $urandom; pc_i = $urandom; rd_i = 5'($urandom);
      exp_res = a;
      exp_rs  = is_ld ? 2'd0 : rs;
      exp_rw  = (is_st || mis) ? 1'b0 : rw;
      if (is_mem && !mis) begin
         for (int k = 0; k < gd; k++) begin
            check("req_hold", {31'd0, mem_if.mem_req}, 32'd1);
            step();
         end
         check("mem_req", {31'd0, mem_if.mem_req}, 32'd1);
         check("mem_addr", mem_if.mem_addr, {a[31:2], 2'b00});
         check("mem_we", {31'd0, mem_if.mem_we}, {31'd0, is_st});
         if (is_st) begin
            m  = exp_mask(a, f3);
            wd = exp_wdata(sd, f3);
            check("mem_wmask", {28'd0, mem_if.mem_wmask}, {28'd0, m});
            check("mem_wdata", mem_if.mem_wdata, wd);
            wb = int'(a[5:2]) * 4;
            for (int i = 0; i < 4; i++) if (m[i]) bmem[wb + i] = wd[8*i +: 8];
         end else begin
            check("mem_wmask_ld", {28'd0, mem_if.mem_wmask}, 32'd0);
         end
         mem_if.mem_rdata  = mem_word(a);
         mem_if.mem_gnt    = 1'b1;
         mem_if.mem_rvalid = (rdd == 0);
         step();
         mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
         if (rdd > 0) begin
            for (int k = 1; k < rdd; k++) begin
               check("wait_no_req", {31'd0, mem_if.mem_req}, 32'd0);
               check("wait_no_out", {31'd0, out_valid}, 32'd0);
               step();
            end
            mem_if.mem_rvalid = 1'b1;
            step();
            mem_if.mem_rvalid = 1'b0;
         end
         mem_if.mem_rdata = $urandom;
         if (is_ld) exp_res = exp_load(a, f3);
      end else if (is_mem) begin
         check("mis_no_req", {31'd0, mem_if.mem_req}, 32'd0);
      end
      for (int k = 0; k <= hold; k++) begin
         check("out_valid", {31'd0, out_valid}, 32'd1);
         check("in_ready_busy", {31'd0, in_ready}, 32'd0);
         if (!is_st || mis) check("result", result_o, exp_res);
         check("rd", {27'd0, rd_o}, {27'd0, rdn});
         check("regS", {30'd0, regS_o}, {30'd0, exp_rs});
         check("RegW", {31'd0, RegW_o}, {31'd0, exp_rw});
         check("pc", pc_o, pcv);
         check("done_no_req", {31'd0, mem_if.mem_req}, 32'd0);
         check("lsu_err", {31'd0, lsu_err}, {31'd0, mis});
         in_valid  = (k < hold);
         MemRd = 1'($urandom); MemWr = 1'($urandom);
         out_ready = (k == hold);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
      check("out_valid_clr", {31'd0, out_valid}, 32'd0);
      check("in_ready_back", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_timeout();
      int n_req;
      exu_result_i = 32'h8000_0010; funct3_i = F3_W; MemRd = 1'b1; MemWr = 1'b0;
      rd_i = 5'd7; regS_i = 2'd0; RegW_i = 1'b1; pc_i = 32'h8000_0100; in_valid = 1'b1;
      step();
      in_valid = 1'b0; MemRd = 1'b0;
      n_req = 0;
      for (int k = 0; k < 300 && !out_valid; k++) begin
         if (mem_if.mem_req) n_req++;
         if (k == 100) check("to_err_early", {31'd0, lsu_err}, 32'd0);
         step();
      end
      check("to_reached_done", {31'd0, out_valid}, 32'd1);
      check("to_req_cycles", n_req, 32'd255);
      check("to_err", {31'd0, lsu_err}, 32'd1);
      check("to_result", result_o, 32'd0);
      check("to_RegW", {31'd0, RegW_o}, 32'd0);
      check("to_req_drop", {31'd0, mem_if.mem_req}, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("to_err_sticky", {31'd0, lsu_err}, 32'd1);
      do_reset();
      check("to_err_reset", {31'd0, lsu_err}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f3_tab [0:5];
      logic [2:0] f3;
      logic [31:0] a;
      int kind;
      f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W;
      f3_tab[3] = F3_BU; f3_tab[4] = F3_HU; f3_tab[5] = 3'b011;
      for (int i = 0; i < 64; i++) bmem[i] = 8'($urandom);
      in_valid = 1'b0; out_ready = 1'b0; exu_result_i = 32'd0; store_data_i = 32'd0;
      funct3_i = 3'd0; MemRd = 1'b0; MemWr = 1'b0; rd_i = 5'd0; regS_i = 2'd0;
      RegW_i = 1'b0; pc_i = 32'd0;
      mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'd0;
      rst = 1'b0;
      step(); step();
      rst = 1'b1;

      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_if.mem_we}, 32'd0);
      check("rst_wmask", {28'd0, mem_if.mem_wmask}, 32'd0);
      check("rst_err", {31'd0, lsu_err}, 32'd0);
      check("rst_result", result_o, 32'd0);

      // ALU pass-through, sign-extended byte load, halfword store, backpressure
      do_op(1'b0, 1'b0, F3_B, 32'h0000_1234, 32'd0, 5'd3, 2'd2, 1'b1, 0, 0, 0);
      bmem[0] = 8'h00; bmem[1] = 8'h00; bmem[2] = 8'hFF; bmem[3] = 8'h80;
      do_op(1'b1, 1'b0, F3_B, 32'h8000_0003, 32'd0, 5'd5, 2'd1, 1'b1, 2, 3, 0);
      do_op(1'b0, 1'b1, F3_H, 32'h8000_0002, 32'hABCD_1234, 5'd6, 2'd0, 1'b1, 1, 1, 0);
      do_op(1'b1, 1'b0, F3_W, 32'h8000_0004, 32'd0, 5'd9, 2'd0, 1'b1, 0, 0, 5);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         a = 32'h8000_0000 | 32'($urandom_range(0, 63));
         if (kind == 2) f3 = f3_tab[$urandom_range(0, 2)];
         else           f3 = f3_tab[$urandom_range(0, 5)];
`ifdef LSU_MISALIGN_CHECK_EN
         a = a & ~32'(acc_size(f3) - 1);
`endif
         do_op(kind == 1 || kind == 3, kind >= 2, f3, a, $urandom, 5'($urandom), 2'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // reset during an access; a late rvalid in IDLE must be ignored
      exu_result_i = 32'h8000_0008; funct3_i = F3_W; MemRd = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0; MemRd = 1'b0; mem_if.mem_gnt = 1'b1;
      step();
      mem_if.mem_gnt = 1'b0;
      do_reset();
      mem_if.mem_rvalid = 1'b1;
      step();
      mem_if.mem_rvalid = 1'b0;
      check("late_rvalid_out", {31'd0, out_valid}, 32'd0);
      check("late_rvalid_rdy", {31'd0, in_ready}, 32'd1);
      check("late_rvalid_req", {31'd0, mem_if.mem_req}, 32'd0);

      do_timeout();

`ifdef LSU_MISALIGN_CHECK_EN
      do_op(1'b1, 1'b0, F3_W, 32'h8000_0001, 32'd0, 5'd4, 2'd0, 1'b1, 0, 0, 1);
      do_reset();
      check("mis_err_reset", {31'd0, lsu_err}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
